// File: rtl/uart_pkg.sv
// Shared UART constants, the default divisor calculation and the divisor payload type.
//   OVERSAMPLE_DEF / DIV_W_DEF / FRAC_BITS_DEF : default generator geometry
//   baud_div_t     : {integer, fraction} oversample divisor at default widths
//   baud_div_calc  : round(clk * 2^fb / (baud * os)), the fixed-point divisor
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DIV_W_DEF      = 16;
    localparam int unsigned FRAC_BITS_DEF  = 4;

    typedef struct packed {
        logic [DIV_W_DEF-1:0]     div_int;
        logic [FRAC_BITS_DEF-1:0] div_frac;
    } baud_div_t;

    // Oversample period in clk cycles, scaled by 2^fb and rounded to nearest.
    function automatic longint unsigned baud_div_calc(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned fb
    );
        longint unsigned den;
        den = baud * os;
        return ((clk_hz << fb) + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/baud_gen_frac_os_div.sv
// Divides the oversample tick stream down to bit-rate and mid-bit ticks.
//   clk, rst    : clock, synchronous active-high reset
//   sync_i      : clears the oversample position
//   os_evt_i    : an oversample tick is issued this cycle (registered by the caller)
//   bit_tick_o  : registered, coincides with every OVERSAMPLE-th os tick
//   mid_tick_o  : registered, coincides with the os tick at mid-bit
module baud_os_div
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    input  logic os_evt_i,
    output logic bit_tick_o,
    output logic mid_tick_o
);

    localparam int unsigned      OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'((OVERSAMPLE - 1) / 2);

    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            bit_tick_q, bit_tick_d;
    logic            mid_tick_q, mid_tick_d;

    // Position within the bit advances on each os tick; ticks decoded from the old position.
    always_comb begin
        os_cnt_d   = os_cnt_q;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        if (sync_i) begin
            os_cnt_d = '0;
        end else if (os_evt_i) begin
            bit_tick_d = (os_cnt_q == OS_LAST);
            mid_tick_d = (os_cnt_q == OS_MID);
            os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt_q   <= '0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
        end else begin
            os_cnt_q   <= os_cnt_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
        end
    end

    assign bit_tick_o = bit_tick_q;
    assign mid_tick_o = mid_tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional baud-rate generator.
//   clk, rst     : clock, synchronous active-high reset (dominates all inputs)
//   en_i         : count enable, 0 freezes the counters
//   sync_i       : phase restart pulse
//   div_wr_i     : divisor write strobe for div_int_i / div_frac_i
//   div_int_i    : integer os period in clk cycles (must be >= 2)
//   div_frac_i   : fractional os period in units of 2^-FRAC_BITS
//   os_tick_o    : oversample tick
//   bit_tick_o   : bit-rate tick
//   mid_tick_o   : mid-bit tick
//   cfg_err_o    : pulse for a rejected divisor write
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_DEFAULT = 9600,
    parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF,
    parameter int unsigned DIV_W        = DIV_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic                 div_wr_i,
    input  logic [DIV_W-1:0]     div_int_i,
    input  logic [FRAC_BITS-1:0] div_frac_i,
    output logic                 os_tick_o,
    output logic                 bit_tick_o,
    output logic                 mid_tick_o,
    output logic                 cfg_err_o
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned ACC_W = FRAC_BITS + 1;
    localparam longint unsigned DEF_DIV =
        baud_div_calc(64'(CLK_FREQ), 64'(BAUD_DEFAULT), 64'(OVERSAMPLE), 64'(FRAC_BITS));
    localparam logic [DIV_W-1:0]     DEF_INT  = DIV_W'(DEF_DIV >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_DIV);

    typedef struct packed {
        logic [DIV_W-1:0]     div_int;
        logic [FRAC_BITS-1:0] div_frac;
    } div_cfg_t;

    div_cfg_t             act_q, act_d;
    div_cfg_t             shd_q, shd_d;
    logic                 shd_vld_q, shd_vld_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] frac_acc_q, frac_acc_d;
    logic                 carry_q, carry_d;
    logic                 os_tick_q, os_tick_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [CNT_W-1:0]     limit_c;
    logic                 period_end_c;
    logic                 wr_ok_c;
    logic                 pend_c;
    logic                 apply_c;
    logic                 os_evt_c;
    div_cfg_t             stage_c;

    // Current period length; the carry stretches one period by a cycle.
    assign limit_c      = {1'b0, act_q.div_int} + CNT_W'(carry_q);
    // >= so a shorter divisor applied while frozen still ends the running period.
    assign period_end_c = (cnt_q >= limit_c - CNT_W'(1));
    assign wr_ok_c      = div_wr_i && (div_int_i >= DIV_W'(2));
    assign stage_c      = wr_ok_c ? div_cfg_t'({div_int_i, div_frac_i}) : shd_q;
    assign pend_c       = wr_ok_c || shd_vld_q;
    // A staged divisor takes effect on a period boundary, or at once when idle/resyncing.
    assign apply_c      = pend_c && (sync_i || !en_i || period_end_c);
    assign os_evt_c     = en_i && !sync_i && period_end_c;

    // Period counter, fractional accumulator and divisor shadow.
    always_comb begin
        act_d      = act_q;
        shd_d      = stage_c;
        shd_vld_d  = pend_c && !apply_c;
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
        os_tick_d  = 1'b0;
        cfg_err_d  = div_wr_i && !wr_ok_c;
        if (sync_i) begin
            cnt_d      = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
        end else if (en_i) begin
            if (period_end_c) begin
                cnt_d                 = '0;
                os_tick_d             = 1'b1;
                {carry_d, frac_acc_d} = ACC_W'(frac_acc_q) + ACC_W'(act_q.div_frac);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (apply_c) begin
            act_d      = stage_c;
            frac_acc_d = '0;
            carry_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q      <= div_cfg_t'({DEF_INT, DEF_FRAC});
            shd_q      <= '0;
            shd_vld_q  <= 1'b0;
            cnt_q      <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
            os_tick_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            act_q      <= act_d;
            shd_q      <= shd_d;
            shd_vld_q  <= shd_vld_d;
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
            os_tick_q  <= os_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    baud_os_div #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_os_div (
        .clk        (clk),
        .rst        (rst),
        .sync_i     (sync_i),
        .os_evt_i   (os_evt_c),
        .bit_tick_o (bit_tick_o),
        .mid_tick_o (mid_tick_o)
    );

    assign os_tick_o = os_tick_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: two instances (OVERSAMPLE 16 and 4) share one stimulus;
// a tick-schedule model predicts all outputs every cycle, and literal checks pin the model.
`timescale 1ns/1ps
module tb_baud_gen_frac;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned FB    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sync = 1'b0;
    logic             div_wr = 1'b0;
    logic [DIV_W-1:0] div_int = '0;
    logic [FB-1:0]    div_frac = '0;
    logic [1:0]       os_tick, bit_tick, mid_tick, cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_gen_frac #(.OVERSAMPLE(16)) u_dut0 (
        .clk(clk), .rst(rst), .en_i(en), .sync_i(sync), .div_wr_i(div_wr),
        .div_int_i(div_int), .div_frac_i(div_frac),
        .os_tick_o(os_tick[0]), .bit_tick_o(bit_tick[0]),
        .mid_tick_o(mid_tick[0]), .cfg_err_o(cfg_err[0])
    );

    baud_gen_frac #(.OVERSAMPLE(4)) u_dut1 (
        .clk(clk), .rst(rst), .en_i(en), .sync_i(sync), .div_wr_i(div_wr),
        .div_int_i(div_int), .div_frac_i(div_frac),
        .os_tick_o(os_tick[1]), .bit_tick_o(bit_tick[1]),
        .mid_tick_o(mid_tick[1]), .cfg_err_o(cfg_err[1])
    );

    // ---------------- model ----------------
    // Period k after a restart ends when (k+1)*I + floor(k*F/2^FB) active cycles have elapsed.
    function automatic int def_div(input int os);
        longint den;
        den = longint'(9600) * longint'(os);
        return int'((longint'(50_000_000) * 16 + den / 2) / den);
    endfunction

    function automatic int target(input int k, input int i, input int f);
        return (k + 1) * i + (k * f) / (1 << FB);
    endfunction

    function automatic int prev_end(input int k, input int i, input int f);
        return (k == 0) ? 0 : k * i + ((k - 1) * f) / (1 << FB);
    endfunction

    int  m_n[2], m_k[2], m_j[2], m_i[2], m_f[2], m_pi[2], m_pf[2];
    bit  m_pend[2];
    bit  [1:0] e_os, e_bit, e_mid, e_cfg;
    bit  model_ok = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int os;
            int cur;
            os = (d == 0) ? 16 : 4;
            e_os[d]  = 1'b0;
            e_bit[d] = 1'b0;
            e_mid[d] = 1'b0;
            e_cfg[d] = 1'b0;
            if (rst) begin
                m_n[d] = 0; m_k[d] = 0; m_j[d] = 0; m_pend[d] = 1'b0;
                m_i[d] = def_div(os) / 16;
                m_f[d] = def_div(os) % 16;
            end else begin
                e_cfg[d] = div_wr && (div_int < 2);
                if (div_wr && div_int >= 2) begin
                    m_pend[d] = 1'b1;
                    m_pi[d]   = int'(div_int);
                    m_pf[d]   = int'(div_frac);
                end
                if (sync) begin
                    m_n[d] = 0; m_k[d] = 0; m_j[d] = 0;
                    if (m_pend[d]) begin
                        m_i[d] = m_pi[d]; m_f[d] = m_pf[d]; m_pend[d] = 1'b0;
                    end
                end else if (!en) begin
                    if (m_pend[d]) begin
                        cur = m_n[d] - prev_end(m_k[d], m_i[d], m_f[d]);
                        m_i[d] = m_pi[d]; m_f[d] = m_pf[d]; m_pend[d] = 1'b0;
                        m_n[d] = cur; m_k[d] = 0;
                    end
                end else begin
                    m_n[d]++;
                    if (m_n[d] >= target(m_k[d], m_i[d], m_f[d])) begin
                        e_os[d]  = 1'b1;
                        e_bit[d] = (m_j[d] % os) == os - 1;
                        e_mid[d] = (m_j[d] % os) == (os - 1) / 2;
                        m_j[d]++;
                        if (m_pend[d]) begin
                            m_i[d] = m_pi[d]; m_f[d] = m_pf[d]; m_pend[d] = 1'b0;
                            m_n[d] = 0; m_k[d] = 0;
                        end else begin
                            m_k[d]++;
                        end
                    end
                end
            end
        end
        model_ok = 1'b1;
    end

    task automatic chk_bit(input string name, input int d, input logic got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %b expected %b", name, d, $time, got, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 2; d++) begin
                chk_bit("os_tick", d, os_tick[d], e_os[d]);
                chk_bit("bit_tick", d, bit_tick[d], e_bit[d]);
                chk_bit("mid_tick", d, mid_tick[d], e_mid[d]);
                chk_bit("cfg_err", d, cfg_err[d], e_cfg[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_tick(input int d, input int budget, output int gap);
        gap = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            gap++;
            if (os_tick[d]) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tick dut%0d: no os_tick within %0d cycles", d, budget);
        gap = -1;
    endtask

    task automatic do_write(input int i, input int f);
        div_wr   = 1'b1;
        div_int  = DIV_W'(i);
        div_frac = FB'(f);
        @(negedge clk);
        div_wr   = 1'b0;
    endtask

    initial begin
        int g;
        int n;
        int mid_at;
        int bit_at;
        int frozen;
        int exp_g[4];
        exp_g = '{325, 326, 325, 326};

        repeat (3) @(negedge clk);
        lit("reset_os_tick", int'(os_tick), 0);
        lit("reset_cfg_err", int'(cfg_err), 0);

        // 1: default divisor 325 + 8/16 -> first period 325, then 325/326 alternating
        rst = 1'b0;
        en  = 1'b1;
        wait_tick(0, 400, g);
        lit("t1_first_gap", g, 325);
        for (int p = 0; p < 4; p++) begin
            wait_tick(0, 400, g);
            lit($sformatf("t1_gap%0d", p), g, exp_g[p]);
        end
        n = 5; mid_at = 0; bit_at = 0;
        for (int p = 0; p < 12 && bit_at == 0; p++) begin
            wait_tick(0, 400, g);
            n++;
            if (mid_tick[0] && mid_at == 0) mid_at = n;
            if (bit_tick[0]) bit_at = n;
        end
        lit("t1_mid_on_os8", mid_at, 8);
        lit("t1_bit_on_os16", bit_at, 16);

        // 2: int=4 frac=0 -> os every 4, 4 os per bit, mid on 2nd os of the bit
        do_write(4, 0);
        repeat (1400) @(negedge clk);
        wait_tick(1, 10, g);
        wait_tick(1, 10, g);
        lit("t2_gap4", g, 4);
        for (int p = 0; p < 8 && !bit_tick[1]; p++) wait_tick(1, 10, g);
        n = 0; mid_at = 0;
        for (int p = 0; p < 8; p++) begin
            wait_tick(1, 10, g);
            n++;
            if (mid_tick[1]) mid_at = n;
            if (bit_tick[1]) break;
        end
        lit("t2_os_per_bit", n, 4);
        lit("t2_mid_pos", mid_at, 2);

        // 3: write int=10 just after a tick -> running 4-cycle period completes first
        wait_tick(1, 10, g);
        do_write(10, 0);
        wait_tick(1, 10, g);
        lit("t3_old_period_done", g, 3);
        wait_tick(1, 20, g);
        lit("t3_gap10_a", g, 10);
        wait_tick(1, 20, g);
        lit("t3_gap10_b", g, 10);

        // 4: int=1 rejected with a single cfg_err pulse; int=2 accepted
        do_write(1, 0);
        lit("t4_cfg_err_hi", int'(cfg_err[1]), 1);
        @(negedge clk);
        lit("t4_cfg_err_lo", int'(cfg_err[1]), 0);
        wait_tick(1, 20, g);
        wait_tick(1, 20, g);
        lit("t4_period_kept", g, 10);
        do_write(2, 0);
        wait_tick(1, 20, g);
        wait_tick(1, 20, g);
        lit("t4_gap2", g, 2);

        // 5: sync at cnt=3 with int=8
        do_write(8, 0);
        wait_tick(1, 20, g);
        wait_tick(1, 20, g);
        lit("t5_gap8", g, 8);
        repeat (3) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        lit("t5_no_tick_after_sync", int'(os_tick[1]), 0);
        wait_tick(1, 20, g);
        lit("t5_tick_8_after_sync", g, 8);
        n = 1;
        for (int p = 0; p < 8 && !bit_tick[1]; p++) begin
            wait_tick(1, 20, g);
            n++;
        end
        lit("t5_os_cnt_restart", n, 4);
        // write together with sync -> new divisor from the very next period
        div_wr = 1'b1; div_int = DIV_W'(5); div_frac = '0; sync = 1'b1;
        @(negedge clk);
        div_wr = 1'b0; sync = 1'b0;
        wait_tick(1, 20, g);
        lit("t5_wr_sync_gap5", g, 5);

        // 6: freeze at cnt=3 (int=5) for 50 cycles, resume, then reset mid-period
        wait_tick(1, 20, g);
        repeat (3) @(negedge clk);
        en = 1'b0;
        frozen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (os_tick != 2'b00 || bit_tick != 2'b00 || mid_tick != 2'b00) frozen++;
        end
        lit("t6_no_ticks_frozen", frozen, 0);
        en = 1'b1;
        wait_tick(1, 20, g);
        lit("t6_resume_remaining", g, 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_tick(1, 1400, g);
        lit("t6_reset_restores_def", g, 1302);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
